alu_exec_32: RTL and testbench

- Execute-stage ALU that consumes the 4-bit alu_control code produced by the ALU control decoder. This is the receiving end of that interface.
- Simple ops (and, or, add, sub, slt) complete in one registered cycle.
- Multiply (code 1000) and divide (code 1001) run iteratively, using a start/busy/done handshake that the pipeline controller uses to stall.
- Produces a primary result plus a hi word: multiply upper half, or divide remainder.

---
 rtl/alu_exec_32.sv | 195 +++++++++++++++++++
 tb/tb_alu_exec_32.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_32.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative unsigned mul/div.
// Latency: simple ops 1 cycle; mul/div WIDTH+1 cycles from accept to done; div-by-zero 1 cycle.
// Backpressure: busy stalls the pipeline; start is sampled only when idle and is dropped, not queued, while busy.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start               operation request (sampled only when busy=0)
//   alu_control[3:0]    0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 mul, 1001 div, others add
//   operand_a/b         operands (rs, rt)
//   result, hi          primary result / product high half or remainder
//   zero                result == 0
//   busy, done          iterative op in progress / one-cycle completion pulse
//   div_by_zero         divide with operand_b == 0 reported alongside done
module alu_exec_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] op_q, op_d;          // multiplicand (mul) or divisor (div)
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;  // partial product high / running remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;  // multiplier bits / dividend-to-quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  // Single-cycle ops
  logic [WIDTH-1:0] simple_res;
  logic             slt_bit;

  assign slt_bit = $signed(operand_a) < $signed(operand_b);

  always_comb begin
    case (alu_control)
      4'b0000: simple_res = operand_a & operand_b;
      4'b0001: simple_res = operand_a | operand_b;
      4'b0110: simple_res = operand_a - operand_b;
      4'b0111: simple_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: simple_res = operand_a + operand_b;
    endcase
  end

  // Shift-add multiply step: conditionally add multiplicand into the high half,
  // then shift the whole {carry, hi, lo} right by one. After WIDTH steps {hi,lo}=a*b.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : {(WIDTH+1){1'b0}});
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder, subtract
  // the divisor when it fits, and shift the outcome bit into the quotient.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n, div_quo_n;

  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, op_q};
  // When the divisor does not fit, div_shift < divisor so it already fits WIDTH bits.
  assign div_rem_n = WIDTH'(div_ge ? (div_shift - {1'b0, op_q}) : div_shift);
  assign div_quo_n = {acc_lo_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    result_d = result_q;
    hi_d     = hi_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;

    case (state_q)
      S_MUL: begin
        acc_hi_d = mul_hi_n;
        acc_lo_d = mul_lo_n;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          result_d = mul_lo_n;
          hi_d     = mul_hi_n;
          zero_d   = (mul_lo_n == '0);
          done_d   = 1'b1;
        end
      end
      S_DIV: begin
        acc_hi_d = div_rem_n;
        acc_lo_d = div_quo_n;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = S_IDLE;
          result_d = div_quo_n;
          hi_d     = div_rem_n;
          zero_d   = (div_quo_n == '0);
          done_d   = 1'b1;
        end
      end
      default: begin
        if (start) begin
          dbz_d = 1'b0;
          case (alu_control)
            4'b1000: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              op_d     = operand_a;
              acc_hi_d = '0;
              acc_lo_d = operand_b;
            end
            4'b1001: begin
              if (operand_b == '0) begin
                // Reported immediately; no iterations are spent on it.
                result_d = '1;
                hi_d     = operand_a;
                zero_d   = 1'b0;
                dbz_d    = 1'b1;
                done_d   = 1'b1;
              end else begin
                state_d  = S_DIV;
                cnt_d    = '0;
                op_d     = operand_b;
                acc_hi_d = '0;
                acc_lo_d = operand_a;
              end
            end
            default: begin
              result_d = simple_res;
              hi_d     = '0;
              zero_d   = (simple_res == '0);
              done_d   = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      result_q <= '0;
      hi_q     <= '0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign result      = result_q;
  assign hi          = hi_q;
  assign zero        = zero_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_exec_32.sv
// Bench for alu_exec_32: directed vector table, multi-cycle corner sequences, random mul/div.
// Latency: measured as edges after the accept edge until done is seen.
// Backpressure: start pulses while busy must be dropped.
module tb_alu_exec_32;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  alu_control;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  alu_exec_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .alu_control (alu_control),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .result      (result),
    .hi          (hi),
    .zero        (zero),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [31:0] exp_hi;
    logic        exp_zero;
    logic        exp_dbz;
    int          exp_lat;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // busy and done must never overlap
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (busy && done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b at %0t", busy, done, $time);
      end
    end
  end

  // Present one op, return edges after the accept edge until done (bounded).
  task automatic issue(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    @(negedge clk);
    start = 1'b1; alu_control = code; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, nd, nb, done_cyc;
    logic [31:0] cap_res, cap_hi;
    logic [31:0] ra, rb;
    logic [63:0] prod;
    logic [3:0]  rc;

    vecs[0]  = '{4'b0010, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 32'h0, 1'b0, 1'b0, 0};
    vecs[1]  = '{4'b0110, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 0};
    vecs[2]  = '{4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 32'h0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 32'h0, 1'b0, 1'b0, 0};
    vecs[5]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 0};
    vecs[6]  = '{4'b1111, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 32'h0, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h1, 1'b0, 1'b0, 32};
    vecs[8]  = '{4'b1001, 32'd100,       32'd7,         32'd14,        32'd2, 1'b0, 1'b0, 32};
    vecs[9]  = '{4'b1001, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 0};
    vecs[10] = '{4'b1000, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 32};
    vecs[11] = '{4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 0};
    vecs[12] = '{4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 32'h0, 1'b0, 1'b0, 0};
    vecs[13] = '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32};
    vecs[14] = '{4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 1'b1, 1'b0, 32};

    reset = 1'b1; start = 1'b0; alu_control = 4'b0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", result, 0);
    chk("reset_hi", hi, 0);
    chk("reset_flags", {zero, busy, done, div_by_zero}, 0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].code, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
      chk($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_zero", i), zero, vecs[i].exp_zero);
      chk($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].exp_dbz);
    end

    // Multiply with start pulses while busy: exactly one done, 32 busy cycles
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1000; operand_a = 32'hFFFF_FFFF; operand_b = 32'h2;
    @(posedge clk); #1;
    start = 1'b0;
    nb = busy ? 1 : 0; nd = 0; done_cyc = -1; cap_res = '0; cap_hi = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = (c < 6 && (c % 2) == 0);
      alu_control = 4'b0010; operand_a = 32'h1; operand_b = 32'h1;
      @(posedge clk); #1;
      if (busy) nb++;
      if (done) begin
        nd++;
        if (nd == 1) begin
          done_cyc = c + 1;
          cap_res = result;
          cap_hi = hi;
        end
      end
    end
    start = 1'b0;
    chk("ignore_start_done_count", nd, 1);
    chk("ignore_start_busy_cycles", nb, 32);
    chk("ignore_start_done_edge", done_cyc, 32);
    chk("ignore_start_result", cap_res, 32'hFFFF_FFFE);
    chk("ignore_start_hi", cap_hi, 32'h1);

    // Back-to-back: OR request held through the mul's done cycle
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1000; operand_a = 32'd3; operand_b = 32'd4;
    @(posedge clk); #1;
    alu_control = 4'b0001; operand_a = 32'hF0; operand_b = 32'h0F;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b_mul_latency", lat, 32);
    chk("b2b_mul_result", result, 32'd12);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_or_done", done, 1);
    chk("b2b_or_result", result, 32'hFF);
    chk("b2b_or_hi", hi, 0);
    @(posedge clk); #1;
    chk("b2b_no_extra_done", done, 0);

    // Reset during divide iteration 10
    @(negedge clk);
    start = 1'b1; alu_control = 4'b1001; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rstdiv_busy_before", busy, 1);
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rstdiv_result", result, 0);
    chk("rstdiv_hi", hi, 0);
    chk("rstdiv_flags", {zero, busy, done, div_by_zero}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("rstdiv_no_done", nd, 0);
    issue(4'b1001, 32'd9, 32'd3, lat);
    chk("post_rst_div_latency", lat, 32);
    chk("post_rst_div_result", result, 32'd3);
    chk("post_rst_div_hi", hi, 0);

    // Random mul/div against reference arithmetic
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = ((i % 4) == 1) ? $urandom_range(1, 255) : $urandom;
      if (rb == 0) rb = 32'd1;
      rc = i[0] ? 4'b1001 : 4'b1000;
      issue(rc, ra, rb, lat);
      if (rc == 4'b1000) begin
        prod = {32'h0, ra} * {32'h0, rb};
        chk($sformatf("rnd%0d_mul", i), {hi, result}, prod);
      end else begin
        chk($sformatf("rnd%0d_div", i), {hi, result}, {ra % rb, ra / rb});
      end
      chk($sformatf("rnd%0d_latency", i), lat, 32);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
